// File: rtl/rob_retire_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_pkg
// Description : Shared sizing constants and record types for the reorder
//               buffer: the ROB_Entry record written by dispatch, the
//               Retire_uOP record handed to rename commit, and index/count
//               types.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_retire_pkg;

    localparam int NUM_ROB_ENTS = 64;   // must be a power of two
    localparam int DISP_WIDTH   = 2;
    localparam int RETIRE_WIDTH = 4;
    localparam int NUM_FUS      = 4;
    localparam int NUM_AREGS    = 32;

    localparam int IW  = $clog2(NUM_ROB_ENTS);
    localparam int CW  = IW + 1;
    localparam int AW  = $clog2(NUM_AREGS);
    localparam int PCW = 32;

    typedef logic [IW-1:0]  rob_idx_t;
    typedef logic [CW-1:0]  rob_cnt_t;
    typedef logic [AW-1:0]  areg_t;

    typedef struct packed {
        areg_t          dst_reg;
        logic           exception;
        logic           br_mispred;
        logic [PCW-1:0] pc;
    } ROB_Entry;

    typedef struct packed {
        areg_t          dst_reg;
        logic [PCW-1:0] pc;
    } Retire_uOP;

    // Number of set lanes in a dispatch-valid vector.
    function automatic rob_cnt_t lane_count(input logic [DISP_WIDTH-1:0] v);
        rob_cnt_t c;
        c = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            c = c + rob_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_if
// Description : Bundle of the dispatch, FU-completion, retire and flush
//               signals of the reorder buffer.
//               master : dispatch/FU side (drives requests, sees results)
//               slave  : the ROB itself
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_retire_if;
    import rob_retire_pkg::*;

    // dispatch / allocate
    logic     [DISP_WIDTH-1:0]               disp_valid;
    ROB_Entry [DISP_WIDTH-1:0]               disp_entry;
    logic                                    disp_ready;
    rob_idx_t [DISP_WIDTH-1:0]               disp_rob_idx;

    // FU completion
    logic     [NUM_FUS-1:0]                  cmpl_valid;
    rob_idx_t [NUM_FUS-1:0]                  cmpl_rob_idx;
    logic     [NUM_FUS-1:0]                  cmpl_exception;
    logic     [NUM_FUS-1:0]                  cmpl_br_mispred;

    // retire / flush
    logic     [RETIRE_WIDTH-1:0]             ret_valid;
    areg_t    [RETIRE_WIDTH-1:0]             ret_dst_reg;
    logic     [RETIRE_WIDTH-1:0][PCW-1:0]    ret_pc;
    logic                                    flush_valid;
    logic                                    flush_exception;
    logic     [PCW-1:0]                      flush_pc;

    modport master (
        output disp_valid, disp_entry,
        output cmpl_valid, cmpl_rob_idx, cmpl_exception, cmpl_br_mispred,
        input  disp_ready, disp_rob_idx,
        input  ret_valid, ret_dst_reg, ret_pc,
        input  flush_valid, flush_exception, flush_pc
    );

    modport slave (
        input  disp_valid, disp_entry,
        input  cmpl_valid, cmpl_rob_idx, cmpl_exception, cmpl_br_mispred,
        output disp_ready, disp_rob_idx,
        output ret_valid, ret_dst_reg, ret_pc,
        output flush_valid, flush_exception, flush_pc
    );

endinterface
`default_nettype wire

// File: rtl/rob_retire_select.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire_select
// Description : Combinational scan of the retire window (head .. head+RW-1).
//               Retires consecutive valid+done entries from lane 0, stops at
//               the first entry that is not ready, and reports the first
//               flushing entry (exception: not retired; mispredict: retired
//               and ends the window).
// Ports       : win_valid_i/win_done_i/win_entry_i - window state, lane k = head+k
//               ret_valid_o/ret_uop_o              - retiring lanes (packed from 0)
//               nret_o                             - number of retiring lanes
//               flush_valid_o/flush_exception_o/flush_pc_o - flush request
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire_select
    import rob_retire_pkg::*;
(
    input  wire logic      [RETIRE_WIDTH-1:0] win_valid_i,
    input  wire logic      [RETIRE_WIDTH-1:0] win_done_i,
    input  wire ROB_Entry  [RETIRE_WIDTH-1:0] win_entry_i,
    output      logic      [RETIRE_WIDTH-1:0] ret_valid_o,
    output      Retire_uOP [RETIRE_WIDTH-1:0] ret_uop_o,
    output      rob_cnt_t                     nret_o,
    output      logic                         flush_valid_o,
    output      logic                         flush_exception_o,
    output      logic      [PCW-1:0]          flush_pc_o
);

    logic w_stop;

    always_comb begin
        ret_valid_o       = '0;
        ret_uop_o         = '0;
        nret_o            = '0;
        flush_valid_o     = 1'b0;
        flush_exception_o = 1'b0;
        flush_pc_o        = '0;
        w_stop            = 1'b0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (!w_stop) begin
                if (win_valid_i[k] && win_done_i[k]) begin
                    if (win_entry_i[k].exception) begin
                        // Faulting entry stays un-retired; it and later lanes are dropped.
                        flush_valid_o     = 1'b1;
                        flush_exception_o = 1'b1;
                        flush_pc_o        = win_entry_i[k].pc;
                        w_stop            = 1'b1;
                    end else begin
                        ret_valid_o[k]       = 1'b1;
                        ret_uop_o[k].dst_reg = win_entry_i[k].dst_reg;
                        ret_uop_o[k].pc      = win_entry_i[k].pc;
                        nret_o               = nret_o + rob_cnt_t'(1);
                        if (win_entry_i[k].br_mispred) begin
                            // Branch itself commits; everything younger is squashed.
                            flush_valid_o = 1'b1;
                            flush_pc_o    = win_entry_i[k].pc;
                            w_stop        = 1'b1;
                        end
                    end
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_retire.sv
`default_nettype none
// ============================================================================
// Module      : rob_retire
// Description : Reorder buffer with in-order commit. Allocates up to
//               DISP_WIDTH entries per cycle at tail, marks entries done on
//               FU completion, retires up to RETIRE_WIDTH consecutive done
//               entries per cycle from head and raises flush on mispredict
//               or exception.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - rob_retire_if.slave (dispatch, completion, retire,
//                      flush signal groups)
// Revision    : 1.0 - initial release
// ============================================================================
module rob_retire
    import rob_retire_pkg::*;
(
    input wire logic   clk,
    input wire logic   rst,
    rob_retire_if.slave bus
);

    // ---------------- state ----------------
    ROB_Entry                  entry_q [NUM_ROB_ENTS];
    logic [NUM_ROB_ENTS-1:0]   valid_q;
    logic [NUM_ROB_ENTS-1:0]   done_q;
    rob_idx_t                  head_q, head_d;
    rob_idx_t                  tail_q, tail_d;
    rob_cnt_t                  count_q, count_d;

    // ---------------- combinational ----------------
    rob_cnt_t                  w_free;
    logic                      w_disp_ready;
    logic [DISP_WIDTH-1:0]     w_disp_fire;
    rob_cnt_t                  w_nalloc;
    rob_idx_t                  w_disp_idx [DISP_WIDTH];

    rob_idx_t                  w_win_idx [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0]   w_win_valid;
    logic [RETIRE_WIDTH-1:0]   w_win_done;
    ROB_Entry [RETIRE_WIDTH-1:0] w_win_entry;

    logic [RETIRE_WIDTH-1:0]   w_ret_valid;
    Retire_uOP [RETIRE_WIDTH-1:0] w_ret_uop;
    rob_cnt_t                  w_nret;
    logic                      w_flush_valid;
    logic                      w_flush_exception;
    logic [PCW-1:0]            w_flush_pc;

    logic [NUM_ROB_ENTS-1:0]   w_cmpl_hit;
    logic [NUM_ROB_ENTS-1:0]   w_cmpl_exc;
    logic [NUM_ROB_ENTS-1:0]   w_cmpl_mis;

    // Readiness uses the registered count only: slots freed by this cycle's
    // retire become allocatable next cycle.
    assign w_free       = rob_cnt_t'(NUM_ROB_ENTS) - count_q;
    assign w_disp_ready = (w_free >= rob_cnt_t'(DISP_WIDTH)) && !w_flush_valid;
    assign w_disp_fire  = bus.disp_valid & {DISP_WIDTH{w_disp_ready}};
    assign w_nalloc     = lane_count(w_disp_fire);

    assign bus.disp_ready = w_disp_ready;

    for (genvar l = 0; l < DISP_WIDTH; l++) begin : g_disp_idx
        assign w_disp_idx[l]       = tail_q + rob_idx_t'(l);
        assign bus.disp_rob_idx[l] = w_disp_idx[l];
    end

    // Window indices wrap naturally through the IW-bit adder.
    for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_win
        assign w_win_idx[k]   = head_q + rob_idx_t'(k);
        assign w_win_valid[k] = valid_q[w_win_idx[k]];
        assign w_win_done[k]  = done_q[w_win_idx[k]];
        assign w_win_entry[k] = entry_q[w_win_idx[k]];
    end

    rob_retire_select u_select (
        .win_valid_i       (w_win_valid),
        .win_done_i        (w_win_done),
        .win_entry_i       (w_win_entry),
        .ret_valid_o       (w_ret_valid),
        .ret_uop_o         (w_ret_uop),
        .nret_o            (w_nret),
        .flush_valid_o     (w_flush_valid),
        .flush_exception_o (w_flush_exception),
        .flush_pc_o        (w_flush_pc)
    );

    assign bus.ret_valid       = w_ret_valid;
    assign bus.flush_valid     = w_flush_valid;
    assign bus.flush_exception = w_flush_exception;
    assign bus.flush_pc        = w_flush_pc;

    for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_ret
        assign bus.ret_dst_reg[k] = w_ret_uop[k].dst_reg;
        assign bus.ret_pc[k]      = w_ret_uop[k].pc;
    end

    // Merge completions per entry so two ports hitting the same index OR
    // their flags instead of one overwriting the other.
    always_comb begin
        w_cmpl_hit = '0;
        w_cmpl_exc = '0;
        w_cmpl_mis = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (bus.cmpl_valid[f] && valid_q[bus.cmpl_rob_idx[f]]) begin
                w_cmpl_hit[bus.cmpl_rob_idx[f]] = 1'b1;
                w_cmpl_exc[bus.cmpl_rob_idx[f]] = w_cmpl_exc[bus.cmpl_rob_idx[f]] | bus.cmpl_exception[f];
                w_cmpl_mis[bus.cmpl_rob_idx[f]] = w_cmpl_mis[bus.cmpl_rob_idx[f]] | bus.cmpl_br_mispred[f];
            end
        end
    end

    // ---------------- pointer / count next state ----------------
    always_comb begin
        head_d  = head_q + rob_idx_t'(w_nret);
        tail_d  = tail_q + rob_idx_t'(w_nalloc);
        count_d = count_q + w_nalloc - w_nret;
        if (w_flush_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ---------------- entry storage ----------------
    // Order inside the cycle: completion, then retire clear, then allocate.
    // Allocation never targets a slot retired in the same cycle because
    // readiness is computed from the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (w_flush_valid) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            for (int e = 0; e < NUM_ROB_ENTS; e++) begin
                if (w_cmpl_hit[e]) begin
                    done_q[e]             <= 1'b1;
                    entry_q[e].exception  <= entry_q[e].exception  | w_cmpl_exc[e];
                    entry_q[e].br_mispred <= entry_q[e].br_mispred | w_cmpl_mis[e];
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (w_ret_valid[k]) begin
                    valid_q[w_win_idx[k]] <= 1'b0;
                    done_q[w_win_idx[k]]  <= 1'b0;
                end
            end
            for (int l = 0; l < DISP_WIDTH; l++) begin
                if (w_disp_fire[l]) begin
                    entry_q[w_disp_idx[l]] <= bus.disp_entry[l];
                    valid_q[w_disp_idx[l]] <= 1'b1;
                    // An entry faulting at dispatch needs no FU; it is ready to flush.
                    done_q[w_disp_idx[l]]  <= bus.disp_entry[l].exception;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_retire.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_retire
// Description : Directed self-checking bench for rob_retire: reset state,
//               in-order retire, full/ready boundary, mispredict and
//               exception flush, same-index completion merge, window wrap
//               and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rob_retire_if bus ();

    rob_retire u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [1:0] v,
                            input logic [31:0] pc0, input logic [4:0] d0,
                            input logic [31:0] pc1, input logic [4:0] d1,
                            input logic ex0);
        bus.disp_valid    = v;
        bus.disp_entry[0] = '{dst_reg: d0, exception: ex0,  br_mispred: 1'b0, pc: pc0};
        bus.disp_entry[1] = '{dst_reg: d1, exception: 1'b0, br_mispred: 1'b0, pc: pc1};
    endtask

    task automatic set_cmpl(input int p, input rob_idx_t idx, input logic ex, input logic mis);
        bus.cmpl_valid[p]      = 1'b1;
        bus.cmpl_rob_idx[p]    = idx;
        bus.cmpl_exception[p]  = ex;
        bus.cmpl_br_mispred[p] = mis;
    endtask

    task automatic clear_cmpl();
        bus.cmpl_valid      = '0;
        bus.cmpl_rob_idx    = '0;
        bus.cmpl_exception  = '0;
        bus.cmpl_br_mispred = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        clear_cmpl();
        step();
        step();
        rst = 1'b0;
    endtask

    // Dispatch 2*pairs entries with pc = base + 4*index.
    task automatic fill_pairs(input int pairs, input logic [31:0] base);
        for (int i = 0; i < pairs; i++) begin
            set_disp(2'b11, base + 32'(8*i), 5'd1, base + 32'(8*i + 4), 5'd2, 1'b0);
            step();
        end
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        // ---- 1: reset and simple two-entry retire ----
        do_reset();
        chk("rst_ret_valid",  64'(bus.ret_valid), 64'h0);
        chk("rst_flush",      64'(bus.flush_valid), 64'h0);
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'h1);
        chk("rst_tail",       64'(bus.disp_rob_idx[0]), 64'h0);
        set_disp(2'b11, 32'h100, 5'd5, 32'h104, 5'd6, 1'b0);
        chk("t1_lane1_idx",   64'(bus.disp_rob_idx[1]), 64'h1);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        chk("t1_tail",        64'(bus.disp_rob_idx[0]), 64'h2);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        set_cmpl(1, 6'd1, 1'b0, 1'b0);
        chk("t1_not_yet",     64'(bus.ret_valid), 64'h0);
        step();
        clear_cmpl();
        chk("t1_ret_valid",   64'(bus.ret_valid), 64'h3);
        chk("t1_ret_pc0",     64'(bus.ret_pc[0]), 64'h100);
        chk("t1_ret_pc1",     64'(bus.ret_pc[1]), 64'h104);
        chk("t1_ret_dst1",    64'(bus.ret_dst_reg[1]), 64'h6);
        step();
        chk("t1_drained",     64'(bus.ret_valid), 64'h0);

        // ---- 2: hole at head blocks retire (entries 2..5) ----
        set_disp(2'b11, 32'h200, 5'd1, 32'h204, 5'd2, 1'b0);
        step();
        set_disp(2'b11, 32'h208, 5'd3, 32'h20c, 5'd4, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd3, 1'b0, 1'b0);
        set_cmpl(1, 6'd4, 1'b0, 1'b0);
        set_cmpl(2, 6'd5, 1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t2_hole",        64'(bus.ret_valid), 64'h0);
        set_cmpl(0, 6'd2, 1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t2_ret_valid",   64'(bus.ret_valid), 64'hf);
        chk("t2_ret_pc0",     64'(bus.ret_pc[0]), 64'h200);
        chk("t2_ret_pc3",     64'(bus.ret_pc[3]), 64'h20c);
        step();
        chk("t2_drained",     64'(bus.ret_valid), 64'h0);

        // ---- 3: full boundary ----
        do_reset();
        fill_pairs(31, 32'h1000);
        chk("t3_ready_at62",  64'(bus.disp_ready), 64'h1);
        set_disp(2'b01, 32'h10f8, 5'd7, 32'h0, 5'd0, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        chk("t3_ready_at63",  64'(bus.disp_ready), 64'h0);
        chk("t3_tail63",      64'(bus.disp_rob_idx[0]), 64'h3f);
        set_disp(2'b11, 32'hdead0, 5'd1, 32'hdead4, 5'd2, 1'b0);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        clear_cmpl();
        chk("t3_ignored",     64'(bus.disp_rob_idx[0]), 64'h3f);
        chk("t3_still_full",  64'(bus.disp_ready), 64'h0);
        chk("t3_ret_one",     64'(bus.ret_valid), 64'h1);
        chk("t3_ret_pc",      64'(bus.ret_pc[0]), 64'h1000);
        step();
        chk("t3_ready_again", 64'(bus.disp_ready), 64'h1);

        // ---- 4: branch mispredict flush ----
        do_reset();
        set_disp(2'b11, 32'h400, 5'd1, 32'h404, 5'd2, 1'b0);
        step();
        set_disp(2'b01, 32'h408, 5'd3, 32'h0, 5'd0, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        set_cmpl(1, 6'd1, 1'b0, 1'b1);
        set_cmpl(2, 6'd2, 1'b0, 1'b0);
        step();
        clear_cmpl();
        set_disp(2'b11, 32'h900, 5'd1, 32'h904, 5'd2, 1'b0);
        chk("t4_ret_valid",   64'(bus.ret_valid), 64'h3);
        chk("t4_flush",       64'(bus.flush_valid), 64'h1);
        chk("t4_flush_exc",   64'(bus.flush_exception), 64'h0);
        chk("t4_flush_pc",    64'(bus.flush_pc), 64'h404);
        chk("t4_ready_low",   64'(bus.disp_ready), 64'h0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        chk("t4_after_flush", 64'(bus.flush_valid), 64'h0);
        chk("t4_after_ret",   64'(bus.ret_valid), 64'h0);
        chk("t4_tail_zero",   64'(bus.disp_rob_idx[0]), 64'h0);
        chk("t4_ready",       64'(bus.disp_ready), 64'h1);

        // ---- 5: exception at dispatch ----
        do_reset();
        set_disp(2'b11, 32'h500, 5'd1, 32'h504, 5'd2, 1'b1);
        step();
        set_disp(2'b11, 32'h508, 5'd3, 32'h50c, 5'd4, 1'b0);
        chk("t5_ret_valid",   64'(bus.ret_valid), 64'h0);
        chk("t5_flush",       64'(bus.flush_valid), 64'h1);
        chk("t5_flush_exc",   64'(bus.flush_exception), 64'h1);
        chk("t5_flush_pc",    64'(bus.flush_pc), 64'h500);
        chk("t5_ready_low",   64'(bus.disp_ready), 64'h0);
        step();
        chk("t5_dropped",     64'(bus.disp_rob_idx[0]), 64'h0);
        set_disp(2'b01, 32'h520, 5'd9, 32'h0, 5'd0, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t5_restart",     64'(bus.ret_valid), 64'h1);
        chk("t5_restart_pc",  64'(bus.ret_pc[0]), 64'h520);

        // ---- 6: window wraps 63 -> 0 ----
        do_reset();
        fill_pairs(31, 32'h2000);
        for (int g = 0; g < 16; g++) begin
            clear_cmpl();
            for (int p = 0; p < 4; p++) begin
                set_cmpl(p, rob_idx_t'(4*g + p), 1'b0, 1'b0);
            end
            step();
        end
        clear_cmpl();
        chk("t6_last_group",  64'(bus.ret_valid), 64'h3);
        step();
        chk("t6_empty",       64'(bus.ret_valid), 64'h0);
        chk("t6_tail62",      64'(bus.disp_rob_idx[0]), 64'h3e);
        set_disp(2'b11, 32'h600, 5'd1, 32'h604, 5'd2, 1'b0);
        step();
        set_disp(2'b11, 32'h608, 5'd3, 32'h60c, 5'd4, 1'b0);
        chk("t6_wrap_idx0",   64'(bus.disp_rob_idx[0]), 64'h0);
        chk("t6_wrap_idx1",   64'(bus.disp_rob_idx[1]), 64'h1);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd62, 1'b0, 1'b0);
        set_cmpl(1, 6'd63, 1'b0, 1'b0);
        set_cmpl(2, 6'd0,  1'b0, 1'b0);
        set_cmpl(3, 6'd1,  1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t6_ret_valid",   64'(bus.ret_valid), 64'hf);
        chk("t6_ret_pc1",     64'(bus.ret_pc[1]), 64'h604);
        chk("t6_ret_pc2",     64'(bus.ret_pc[2]), 64'h608);
        chk("t6_ret_dst3",    64'(bus.ret_dst_reg[3]), 64'h4);
        step();
        set_disp(2'b01, 32'h610, 5'd5, 32'h0, 5'd0, 1'b0);
        chk("t6_tail2",       64'(bus.disp_rob_idx[0]), 64'h2);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd2, 1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t6_head2",       64'(bus.ret_valid), 64'h1);
        chk("t6_head2_pc",    64'(bus.ret_pc[0]), 64'h610);

        // ---- 7: two ports complete the same index; flags merge ----
        do_reset();
        set_disp(2'b11, 32'h700, 5'd1, 32'h704, 5'd2, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        set_cmpl(1, 6'd0, 1'b0, 1'b1);
        set_cmpl(2, 6'd1, 1'b0, 1'b0);
        step();
        clear_cmpl();
        chk("t7_ret_valid",   64'(bus.ret_valid), 64'h1);
        chk("t7_flush",       64'(bus.flush_valid), 64'h1);
        chk("t7_flush_pc",    64'(bus.flush_pc), 64'h700);

        // ---- 8: reset in mid-operation ----
        step();
        set_disp(2'b11, 32'h800, 5'd1, 32'h804, 5'd2, 1'b0);
        step();
        set_disp(2'b00, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
        set_cmpl(0, 6'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_cmpl();
        chk("t8_tail",        64'(bus.disp_rob_idx[0]), 64'h0);
        step();
        chk("t8_no_ret",      64'(bus.ret_valid), 64'h0);
        chk("t8_ready",       64'(bus.disp_ready), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
